mw_add_ctrl: RTL and testbench

Multi-cycle controller that runs one WIDTH-bit cla instance over NLIMB limbs, one limb per clock, to add or subtract wide (WIDTH*NLIMB) operands. The carry is registered between limbs. Operands and results use valid/ready handshakes on both sides. This block lets the ALU and future extended-precision units reuse the existing 32-bit cla instead of instantiating a wide adder.

---
 rtl/add_ctrl_pkg.sv | 15 +
 rtl/cla.sv | 51 +++++
 rtl/mw_add_ctrl.sv | 125 ++++++++++++
 tb/tb_mw_add_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/add_ctrl_pkg.sv
// Shared types and helpers for the multi-limb add/subtract controller.
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a limb counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla.sv
// WIDTH-bit carry-lookahead adder built from 4-bit lookahead groups.
module cla #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned GRP  = 4;
  localparam int unsigned NGRP = (WIDTH + GRP - 1) / GRP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             gg;
  logic             gp;
  int unsigned      lo;
  int unsigned      hi;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    gp   = 1'b1;
    lo   = 0;
    hi   = 0;
    for (int unsigned grp = 0; grp < NGRP; grp++) begin
      lo = grp * GRP;
      hi = (lo + GRP < WIDTH) ? lo + GRP : WIDTH;
      gg = 1'b0;
      gp = 1'b1;
      for (int unsigned i = lo; i < hi; i++) begin
        gg = g[i] | (p[i] & gg);
        gp = gp & p[i];
      end
      // Group carry-out comes straight from group G/P, not from the bit chain.
      c[hi] = gg | (gp & c[lo]);
      for (int unsigned i = lo; i + 1 < hi; i++) begin
        c[i+1] = g[i] | (p[i] & c[i]);
      end
    end
    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/mw_add_ctrl.sv
// Sequences one WIDTH-bit cla over NLIMB limbs (LSB limb first) to add or
// subtract WIDTH*NLIMB-bit operands, with valid/ready on both sides.
module mw_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NLIMB = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH*NLIMB-1:0] i_a,
  input  logic [WIDTH*NLIMB-1:0] i_b,
  input  logic                   i_sub,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH*NLIMB-1:0] o_sum,
  output logic                   o_cout,
  output logic                   o_ovf,
  output logic                   o_busy
);

  localparam int unsigned IDX_W = idx_width(NLIMB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMB - 1);

  state_t state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         carry_q, carry_d;
  logic [NLIMB-1:0][WIDTH-1:0]  a_q, a_d;
  logic [NLIMB-1:0][WIDTH-1:0]  b_q, b_d;
  logic [NLIMB-1:0][WIDTH-1:0]  sum_q, sum_d;
  logic                         cout_q, cout_d;
  logic                         ovf_q, ovf_d;

  logic [WIDTH-1:0] a_limb;
  logic [WIDTH-1:0] b_limb;
  logic [WIDTH-1:0] cla_sum;
  logic             cla_cout;

  assign a_limb = a_q[idx_q];
  assign b_limb = b_q[idx_q];

  cla #(.WIDTH(WIDTH)) u_cla (
    .a    (a_limb),
    .b    (b_limb),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          // Subtraction is A + ~B + 1: invert B once and seed the carry.
          a_d     = i_a;
          b_d     = i_sub ? ~i_b : i_b;
          carry_d = i_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = cla_sum;
        carry_d      = cla_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = cla_cout;
          ovf_d   = (a_limb[WIDTH-1] == b_limb[WIDTH-1]) &&
                    (cla_sum[WIDTH-1] != a_limb[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
    o_busy  = (state_q != IDLE);
    o_sum   = sum_q;
    o_cout  = cout_q;
    o_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_mw_add_ctrl.sv
// Directed bench for mw_add_ctrl (WIDTH=32, NLIMB=4) with hand-computed results.
module tb_mw_add_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NLIMB = 4;
  localparam int unsigned TW    = WIDTH * NLIMB;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [TW-1:0] i_a;
  logic [TW-1:0] i_b;
  logic          i_sub;
  logic          o_valid;
  logic          i_ready;
  logic [TW-1:0] o_sum;
  logic          o_cout;
  logic          o_ovf;
  logic          o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mw_add_ctrl #(.WIDTH(WIDTH), .NLIMB(NLIMB)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present operands for one cycle, check acceptance, then scramble inputs.
  task automatic start_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub);
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    i_valid = 1'b1;
    #1;
    check("ready_before_accept", {127'b0, o_ready}, 1);
    tick();
    check("busy_after_accept", {127'b0, o_busy}, 1);
    i_valid = 1'b0;
    i_a     = {4{32'hDEAD_BEEF}};
    i_b     = {4{32'h1234_5678}};
    i_sub   = ~sub;
  endtask

  // Expect o_valid low for NLIMB-1 cycles after accept, high on the NLIMB-th.
  task automatic wait_result();
    for (int k = 1; k <= NLIMB; k++) begin
      tick();
      check($sformatf("valid_latency_c%0d", k), {127'b0, o_valid}, (k == NLIMB) ? 1 : 0);
    end
  endtask

  task automatic check_result(input string tag, input logic [TW-1:0] s, input logic c, input logic v);
    check({tag, "_sum"},  o_sum, s);
    check({tag, "_cout"}, {127'b0, o_cout}, {127'b0, c});
    check({tag, "_ovf"},  {127'b0, o_ovf},  {127'b0, v});
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("valid_after_release", {127'b0, o_valid}, 0);
    check("ready_after_release", {127'b0, o_ready}, 1);
  endtask

  task automatic run_op(input string tag, input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic sub, input logic [TW-1:0] s, input logic c, input logic v);
    start_op(a, b, sub);
    wait_result();
    check_result(tag, s, c, v);
    release_result();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_sub   = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // Full ripple across limb boundaries, with exact latency.
    run_op("ripple", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
           128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
    run_op("wrap", {128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0);
    run_op("sovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
           128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub5m7", 128'd5, 128'd7, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub7m5", 128'd7, 128'd5, 1'b1, 128'd2, 1'b1, 1'b0);

    // Backpressure: DONE holds while i_valid/i_a toggle.
    start_op(128'd10, 128'd20, 1'b0);
    wait_result();
    for (int k = 0; k < 5; k++) begin
      i_valid = ~i_valid;
      i_a     = i_a + 128'h1_0000_0001;
      tick();
      check($sformatf("bp_valid_%0d", k), {127'b0, o_valid}, 1);
      check($sformatf("bp_sum_%0d", k),   o_sum, 128'd30);
      check($sformatf("bp_ready_%0d", k), {127'b0, o_ready}, 0);
    end
    i_valid = 1'b0;
    release_result();
    tick();
    check("bp_no_accept_busy", {127'b0, o_busy}, 0);
    check("bp_sum_held_idle", o_sum, 128'd30);

    // Async reset mid-DONE clears everything at once.
    start_op(128'd3, 128'd4, 1'b0);
    wait_result();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_ready", {127'b0, o_ready}, 1);
    check("rst_valid", {127'b0, o_valid}, 0);
    check("rst_sum",   o_sum, 128'd0);
    check("rst_cout",  {127'b0, o_cout}, 0);
    check("rst_ovf",   {127'b0, o_ovf}, 0);
    check("rst_busy",  {127'b0, o_busy}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // Reset two cycles after accept aborts with no o_valid pulse.
    start_op(128'd100, 128'd200, 1'b0);
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrun_busy", {127'b0, o_busy}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("midrun_no_valid_%0d", k), {127'b0, o_valid}, 0);
    end
    run_op("after_rst", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
